pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, program counter / instruction address width.
REQ-002 SHALL have parameter OPCODE_WIDTH, default 6, opcode width.
REQ-003 SHALL have parameter STACK_DEPTH, default 8 (power of two), return-address stack entries.
REQ-004 SHALL have parameters OP_JMP=6'h30, OP_JZ=6'h31, OP_CALL=6'h32, OP_RET=6'h33, OP_HALT=6'h3F, the control opcodes; all other opcodes are ALU opcodes.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port start  input  1  leave IDLE/HALT and begin execution at address 0.
REQ-008 SHALL have port instr_op  input  OPCODE_WIDTH  opcode returned by program memory, valid in EXEC.
REQ-009 SHALL have port instr_target  input  PC_WIDTH  jump/call target, valid in EXEC.
REQ-010 SHALL have port zero_flag  input  1  ALU zero flag, sampled in EXEC.
REQ-011 SHALL have port instr_addr  output  PC_WIDTH  program memory address (current PC).
REQ-012 SHALL have port exec_en  output  1  one-cycle strobe: ALU executes instr_op.
REQ-013 SHALL have port push  output  1  one-cycle strobe on accepted CALL.
REQ-014 SHALL have port pop  output  1  one-cycle strobe on accepted RET.
REQ-015 SHALL have port halted  output  1  high in HALT state.
REQ-016 SHALL have port stack_err  output  1  high in ERROR state.
REQ-017 SHALL have port depth  output  $clog2(STACK_DEPTH)+1  current stack occupancy.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, EXEC, HALT, ERROR.
REQ-019 SHALL, in IDLE, hold PC; start=1 sets PC=0, depth=0, next state FETCH.
REQ-020 SHALL spend exactly one cycle in FETCH (synchronous memory read of instr_addr), then go to EXEC.
REQ-021 SHALL, in EXEC with an ALU opcode, assert exec_en for that cycle, set PC=PC+1, go to FETCH (2 cycles per instruction).
REQ-022 SHALL, in EXEC with OP_JMP, set PC=instr_target, go to FETCH; exec_en stays 0.
REQ-023 SHALL, in EXEC with OP_JZ, set PC=instr_target if zero_flag=1, else PC+1; go to FETCH.
REQ-024 SHALL, in EXEC with OP_CALL and depth<STACK_DEPTH, write PC+1 to stack[depth], increment depth, pulse push, set PC=instr_target, go to FETCH.
REQ-025 SHALL, in EXEC with OP_RET and depth>0, set PC=stack[depth-1], decrement depth, pulse pop, go to FETCH.
REQ-026 SHALL, on OP_CALL with depth=STACK_DEPTH (overflow) or OP_RET with depth=0 (underflow), leave PC, depth and stack unchanged, assert no push/pop, go to ERROR.
REQ-027 SHALL, in EXEC with OP_HALT, leave PC unchanged, go to HALT.
REQ-028 SHALL compute PC+1 modulo 2^PC_WIDTH (address 2^PC_WIDTH-1 wraps to 0; return address wraps likewise).
REQ-029 SHALL, in HALT or ERROR, hold all state; start=1 restarts as in REQ-019 and clears stack_err.
REQ-030 SHALL ignore start in FETCH and EXEC.
REQ-031 SHALL drive instr_addr directly from the PC register; exec_en, push, pop mutually exclusive and never high outside EXEC.

Reset
REQ-032 SHALL, on rst=1 at any time including mid-instruction, immediately enter IDLE with PC=0, depth=0, exec_en=0, push=0, pop=0, halted=0, stack_err=0; stack contents need not be cleared.
REQ-033 SHALL resume normal operation on the first rising edge after rst deasserts, requiring start to leave IDLE.

Verification
REQ-034 SHALL verify linear run: program ALU,ALU,HALT at 0..2, start -> exec_en at cycles 2 and 4 after start, instr_addr 0,1,2, halted=1 with instr_addr=2.
REQ-035 SHALL verify JZ: JZ target 0x10 with zero_flag=1 -> instr_addr=0x10; with zero_flag=0 -> instr_addr=PC+1.
REQ-036 SHALL verify CALL/RET: CALL 0x20 at 0x05, RET at 0x20 -> push pulse, depth=1, instr_addr=0x20, then pop pulse, depth=0, instr_addr=0x06.
REQ-037 SHALL verify overflow/underflow: 9 nested CALLs (depth 8) -> stack_err=1, depth=8, no 9th push; RET at depth 0 -> stack_err=1, no pop.
REQ-038 SHALL verify wrap: ALU op at 0xFF -> next instr_addr=0x00; CALL at 0xFF -> pushed return address 0x00.
REQ-039 SHALL verify async reset asserted in EXEC between clock edges -> outputs return to reset values before the next edge, state IDLE.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer with IDLE/FETCH/EXEC/HALT/ERROR control and a return-address stack.
// Latency: two cycles per instruction (FETCH, then EXEC); the control strobes are combinational in EXEC.
// Backpressure: none; start is accepted only in IDLE, HALT or ERROR, and ignored while executing.
module pc_sequencer #(
  parameter int PC_WIDTH     = 8,
  parameter int OPCODE_WIDTH = 6,
  parameter int STACK_DEPTH  = 8,
  parameter logic [OPCODE_WIDTH-1:0] OP_JMP  = 6'h30,
  parameter logic [OPCODE_WIDTH-1:0] OP_JZ   = 6'h31,
  parameter logic [OPCODE_WIDTH-1:0] OP_CALL = 6'h32,
  parameter logic [OPCODE_WIDTH-1:0] OP_RET  = 6'h33,
  parameter logic [OPCODE_WIDTH-1:0] OP_HALT = 6'h3F
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [OPCODE_WIDTH-1:0]          instr_op,
  input  logic [PC_WIDTH-1:0]              instr_target,
  input  logic                             zero_flag,
  output logic [PC_WIDTH-1:0]              instr_addr,
  output logic                             exec_en,
  output logic                             push,
  output logic                             pop,
  output logic                             halted,
  output logic                             stack_err,
  output logic [$clog2(STACK_DEPTH):0]     depth
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc, pc_nxt, pc_inc;
  logic [DW-1:0]       depth_nxt, top_idx;
  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];

  // Natural-width add gives the modulo-2^PC_WIDTH wrap for both the next PC and the return address.
  assign pc_inc     = pc + 1'b1;
  assign top_idx    = depth - 1'b1;
  assign instr_addr = pc;
  assign halted     = (state == HALT);
  assign stack_err  = (state == ERROR);

  // State, PC and stack-pointer registers; reset drops straight to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      depth <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      depth <= depth_nxt;
    end
  end

  // Return-address storage; contents are don't-care after reset since depth gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      stack[depth[AW-1:0]] <= pc_inc;
    end
  end

  // Next-state, next-PC and strobe decode; strobes can only fire in EXEC.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    depth_nxt = depth;
    exec_en   = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE, HALT, ERROR: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = '0;
          depth_nxt = '0;
        end
      end
      FETCH: state_nxt = EXEC;
      EXEC: begin
        state_nxt = FETCH;
        case (instr_op)
          OP_JMP: pc_nxt = instr_target;
          OP_JZ:  pc_nxt = zero_flag ? instr_target : pc_inc;
          OP_CALL: begin
            if (depth < FULL) begin
              push      = 1'b1;
              depth_nxt = depth + 1'b1;
              pc_nxt    = instr_target;
            end else begin
              state_nxt = ERROR;
            end
          end
          OP_RET: begin
            if (depth != '0) begin
              pop       = 1'b1;
              depth_nxt = top_idx;
              pc_nxt    = stack[top_idx[AW-1:0]];
            end else begin
              state_nxt = ERROR;
            end
          end
          OP_HALT: state_nxt = HALT;
          default: begin
            exec_en = 1'b1;
            pc_nxt  = pc_inc;
          end
        endcase
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random programs against an instruction-level model.
// Program memory is modelled as arrays indexed by instr_addr (PC is stable across FETCH and EXEC).
// All inputs change and all outputs are sampled on the falling clock edge.
module tb_pc_sequencer;

  localparam logic [5:0] OP_JMP  = 6'h30;
  localparam logic [5:0] OP_JZ   = 6'h31;
  localparam logic [5:0] OP_CALL = 6'h32;
  localparam logic [5:0] OP_RET  = 6'h33;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_ALU  = 6'h01;
  localparam int MAXC = 80;

  logic       clk, rst, start, zero_flag;
  logic [5:0] instr_op;
  logic [7:0] instr_target, instr_addr;
  logic       exec_en, push, pop, halted, stack_err;
  logic [3:0] depth;

  logic [5:0] prog_op  [0:255];
  logic [7:0] prog_tgt [0:255];
  logic       zf_mem   [0:255];

  int pass_cnt = 0;
  int total_cnt = 0;

  // Expected per-cycle trace, index 1 = first cycle after start is accepted.
  int e_addr  [1:MAXC];
  int e_depth [1:MAXC];
  bit e_exec [1:MAXC], e_push [1:MAXC], e_pop [1:MAXC], e_halt [1:MAXC], e_err [1:MAXC];

  assign instr_op     = prog_op[instr_addr];
  assign instr_target = prog_tgt[instr_addr];
  assign zero_flag    = zf_mem[instr_addr];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .instr_op(instr_op), .instr_target(instr_target), .zero_flag(zero_flag),
    .instr_addr(instr_addr), .exec_en(exec_en), .push(push), .pop(pop),
    .halted(halted), .stack_err(stack_err), .depth(depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    start = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic start_prog();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) begin
      prog_op[i] = OP_HALT;
      prog_tgt[i] = 8'h00;
      zf_mem[i] = 1'b0;
    end
  endtask

  // Instruction-level interpreter: each instruction is one fetch cycle then one execute cycle.
  task automatic model_run(input int ncyc);
    int pc, mode, c;
    int stk[$];
    logic [5:0] op;
    pc = 0; mode = 0; c = 1; stk.delete();
    while (c <= ncyc) begin
      e_addr[c] = pc; e_depth[c] = stk.size();
      e_exec[c] = 0; e_push[c] = 0; e_pop[c] = 0;
      e_halt[c] = (mode == 1); e_err[c] = (mode == 2);
      if (mode != 0) begin c++; continue; end
      c++;
      if (c > ncyc) break;
      e_addr[c] = pc; e_depth[c] = stk.size();
      e_exec[c] = 0; e_push[c] = 0; e_pop[c] = 0; e_halt[c] = 0; e_err[c] = 0;
      op = prog_op[pc];
      if (op == OP_JMP) pc = prog_tgt[pc];
      else if (op == OP_JZ) pc = zf_mem[pc] ? int'(prog_tgt[pc]) : (pc + 1) % 256;
      else if (op == OP_CALL) begin
        if (stk.size() < 8) begin e_push[c] = 1; stk.push_back((pc + 1) % 256); pc = prog_tgt[pc]; end
        else mode = 2;
      end else if (op == OP_RET) begin
        if (stk.size() > 0) begin e_pop[c] = 1; pc = stk.pop_back(); end
        else mode = 2;
      end else if (op == OP_HALT) mode = 1;
      else begin e_exec[c] = 1; pc = (pc + 1) % 256; end
      c++;
    end
  endtask

  function automatic logic [5:0] rand_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 40) return 6'($urandom_range(0, 47));
    if (r < 48) return 6'($urandom_range(52, 62));
    if (r < 58) return OP_JMP;
    if (r < 70) return OP_JZ;
    if (r < 85) return OP_CALL;
    if (r < 96) return OP_RET;
    return OP_HALT;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    cyc();
    total_cnt++;
    if ({exec_en, push, pop, halted, stack_err} !== 5'b0) $display("FAIL reset_flags got=%b want=00000", {exec_en, push, pop, halted, stack_err});
    else pass_cnt++;
    total_cnt++;
    if (instr_addr !== 8'h00 || depth !== 4'd0) $display("FAIL reset_pc_depth got addr=%h depth=%0d want 00/0", instr_addr, depth);
    else pass_cnt++;
    rst = 1'b0;
    cyc(); cyc();
    total_cnt++;
    if (instr_addr !== 8'h00 || exec_en !== 1'b0) $display("FAIL idle_hold got addr=%h exec_en=%b want 00/0", instr_addr, exec_en);
    else pass_cnt++;
  endtask

  task automatic test_linear();
    int ea [6] = '{0, 0, 1, 1, 2, 2};
    bit ee [6] = '{0, 1, 0, 1, 0, 0};
    clear_prog();
    prog_op[0] = OP_ALU; prog_op[1] = 6'h05; prog_op[2] = OP_HALT;
    do_reset();
    start_prog();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc();
      total_cnt++;
      if (instr_addr !== 8'(ea[c]) || exec_en !== ee[c])
        $display("FAIL linear_c%0d got addr=%h exec_en=%b want %h/%b", c + 1, instr_addr, exec_en, ea[c], ee[c]);
      else pass_cnt++;
    end
    cyc();
    total_cnt++;
    if (halted !== 1'b1 || instr_addr !== 8'h02) $display("FAIL linear_halt got halted=%b addr=%h want 1/02", halted, instr_addr);
    else pass_cnt++;
  endtask

  task automatic test_jz();
    clear_prog();
    prog_op[0] = OP_JZ; prog_tgt[0] = 8'h10; zf_mem[0] = 1'b1;
    prog_op[8'h10] = OP_JZ; prog_tgt[8'h10] = 8'h30; zf_mem[8'h10] = 1'b0;
    do_reset();
    // start held through FETCH and EXEC must not restart the program
    start = 1'b1;
    cyc(); cyc(); cyc();
    start = 1'b0;
    total_cnt++;
    if (instr_addr !== 8'h10) $display("FAIL jz_taken got=%h want=10", instr_addr);
    else pass_cnt++;
    cyc(); cyc();
    total_cnt++;
    if (instr_addr !== 8'h11) $display("FAIL jz_not_taken got=%h want=11", instr_addr);
    else pass_cnt++;
  endtask

  task automatic test_call_ret();
    clear_prog();
    prog_op[0] = OP_JMP; prog_tgt[0] = 8'h05;
    prog_op[5] = OP_CALL; prog_tgt[5] = 8'h20;
    prog_op[8'h20] = OP_RET;
    do_reset();
    start_prog();
    cyc(); cyc(); cyc();
    total_cnt++;
    if (push !== 1'b1 || pop !== 1'b0) $display("FAIL call_push got push=%b pop=%b want 1/0", push, pop);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (instr_addr !== 8'h20 || depth !== 4'd1) $display("FAIL call_target got addr=%h depth=%0d want 20/1", instr_addr, depth);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (pop !== 1'b1 || push !== 1'b0) $display("FAIL ret_pop got pop=%b push=%b want 1/0", pop, push);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (instr_addr !== 8'h06 || depth !== 4'd0) $display("FAIL ret_addr got addr=%h depth=%0d want 06/0", instr_addr, depth);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int pushes;
    clear_prog();
    for (int i = 0; i < 9; i++) begin prog_op[i] = OP_CALL; prog_tgt[i] = 8'(i + 1); end
    do_reset();
    start_prog();
    pushes = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) cyc();
      if (push === 1'b1) pushes++;
    end
    total_cnt++;
    if (stack_err !== 1'b1 || depth !== 4'd8) $display("FAIL overflow_err got err=%b depth=%0d want 1/8", stack_err, depth);
    else pass_cnt++;
    total_cnt++;
    if (pushes != 8 || instr_addr !== 8'h08) $display("FAIL overflow_push got pushes=%0d addr=%h want 8/08", pushes, instr_addr);
    else pass_cnt++;
  endtask

  task automatic test_underflow();
    clear_prog();
    prog_op[0] = OP_RET;
    do_reset();
    start_prog();
    cyc();
    total_cnt++;
    if (pop !== 1'b0) $display("FAIL underflow_pop got=%b want=0", pop);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (stack_err !== 1'b1 || depth !== 4'd0 || instr_addr !== 8'h00) $display("FAIL underflow_err got err=%b depth=%0d addr=%h want 1/0/00", stack_err, depth, instr_addr);
    else pass_cnt++;
    start_prog();
    total_cnt++;
    if (stack_err !== 1'b0 || instr_addr !== 8'h00) $display("FAIL restart_clears got err=%b addr=%h want 0/00", stack_err, instr_addr);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    clear_prog();
    prog_op[0] = OP_JMP; prog_tgt[0] = 8'hFF;
    prog_op[8'hFF] = OP_ALU;
    do_reset();
    start_prog();
    cyc(); cyc(); cyc();
    total_cnt++;
    if (exec_en !== 1'b1 || instr_addr !== 8'hFF) $display("FAIL wrap_alu got exec_en=%b addr=%h want 1/ff", exec_en, instr_addr);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (instr_addr !== 8'h00) $display("FAIL wrap_pc got=%h want=00", instr_addr);
    else pass_cnt++;
    prog_op[8'hFF] = OP_CALL; prog_tgt[8'hFF] = 8'h40;
    prog_op[8'h40] = OP_RET;
    do_reset();
    start_prog();
    for (int c = 2; c <= 7; c++) cyc();
    total_cnt++;
    if (instr_addr !== 8'h00 || depth !== 4'd0) $display("FAIL wrap_ret got addr=%h depth=%0d want 00/0", instr_addr, depth);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    clear_prog();
    prog_op[0] = OP_CALL; prog_tgt[0] = 8'h10;
    prog_op[8'h10] = OP_ALU; prog_op[8'h11] = OP_ALU;
    do_reset();
    start_prog();
    cyc(); cyc(); cyc();
    total_cnt++;
    if (exec_en !== 1'b1 || depth !== 4'd1 || instr_addr !== 8'h10) $display("FAIL arst_pre got exec_en=%b depth=%0d addr=%h want 1/1/10", exec_en, depth, instr_addr);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({exec_en, push, pop, halted, stack_err} !== 5'b0 || instr_addr !== 8'h00 || depth !== 4'd0)
      $display("FAIL arst_mid got flags=%b addr=%h depth=%0d want 00000/00/0", {exec_en, push, pop, halted, stack_err}, instr_addr, depth);
    else pass_cnt++;
    #1 rst = 1'b0;
    cyc(); cyc(); cyc();
    total_cnt++;
    if (instr_addr !== 8'h00 || exec_en !== 1'b0 || push !== 1'b0) $display("FAIL arst_idle got addr=%h exec_en=%b push=%b want 00/0/0", instr_addr, exec_en, push);
    else pass_cnt++;
    start_prog();
    cyc();
    total_cnt++;
    if (push !== 1'b1) $display("FAIL arst_resume got push=%b want 1", push);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 256; i++) begin
        prog_op[i] = rand_op();
        prog_tgt[i] = 8'($urandom_range(0, 255));
        zf_mem[i] = 1'($urandom_range(0, 1));
      end
      do_reset();
      model_run(MAXC);
      start_prog();
      for (int c = 1; c <= MAXC; c++) begin
        if (c > 1) cyc();
        total_cnt++;
        if (instr_addr !== 8'(e_addr[c])) $display("FAIL rand_addr p%0d c%0d got=%h want=%h", p, c, instr_addr, e_addr[c]);
        else pass_cnt++;
        total_cnt++;
        if ({exec_en, push, pop} !== {e_exec[c], e_push[c], e_pop[c]})
          $display("FAIL rand_strobes p%0d c%0d got=%b want=%b", p, c, {exec_en, push, pop}, {e_exec[c], e_push[c], e_pop[c]});
        else pass_cnt++;
        total_cnt++;
        if ({halted, stack_err} !== {e_halt[c], e_err[c]} || depth !== 4'(e_depth[c]))
          $display("FAIL rand_status p%0d c%0d got h/e=%b depth=%0d want %b/%0d", p, c, {halted, stack_err}, depth, {e_halt[c], e_err[c]}, e_depth[c]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    clear_prog();
    test_reset();
    test_linear();
    test_jz();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
